// File: rtl/shifter_arb_pkg.sv
// -----------------------------------------------------------------------------
// shifter_arb_pkg
// Shared constants and types for the shared barrel-shifter arbiter slice.
//   DATA_W / AMT_W       : operand width and shift-amount width
//   DIR_LEFT / DIR_RIGHT : encoding of the per-requester direction bit
//   arb_state_e          : control states of shifter_arbiter
// -----------------------------------------------------------------------------
package shifter_arb_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned AMT_W  = 5;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    // Bit reversal lets one left-shift network serve both directions.
    function automatic logic [DATA_W-1:0] bit_reverse(input logic [DATA_W-1:0] x);
        logic [DATA_W-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            r[i] = x[DATA_W-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/Barrel_Shifter.sv
// -----------------------------------------------------------------------------
// Barrel_Shifter
// Combinational 32-bit logical barrel shifter (zero fill, no rotate).
// Ports:
//   D_IN  in  32  operand
//   AMT   in   5  shift amount 0..31 (0 passes data through)
//   DIR   in   1  0 = left, 1 = right (logical)
//   D_OUT out 32  shifted result
// -----------------------------------------------------------------------------
module Barrel_Shifter
    import shifter_arb_pkg::*;
(
    input  logic [DATA_W-1:0] D_IN,
    input  logic [AMT_W-1:0]  AMT,
    input  logic              DIR,
    output logic [DATA_W-1:0] D_OUT
);

    logic [DATA_W-1:0] stage;

    // Right shifts are done as reverse -> left shift -> reverse, so a single
    // log2 stage network is shared by both directions.
    always_comb begin
        stage = (DIR == DIR_RIGHT) ? bit_reverse(D_IN) : D_IN;
        for (int unsigned s = 0; s < AMT_W; s++) begin
            if (AMT[s]) begin
                stage = stage << (32'd1 << s);
            end
        end
        D_OUT = (DIR == DIR_RIGHT) ? bit_reverse(stage) : stage;
    end

endmodule

// File: rtl/shifter_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin arbiter. The search starts one position
// after `last` and wraps modulo NUM_REQ.
// Ports:
//   req   in  NUM_REQ  request vector
//   last  in  ID_W     most recently granted index
//   en    in  1        grant allowed this cycle
//   grant out NUM_REQ  one-hot grant (zero when disabled or no request)
//   idx   out ID_W     encoded index of the granted requester
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last,
    input  logic               en,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    idx
);

    logic            found;
    logic [ID_W-1:0] cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = ID_W'((32'(last) + k) % NUM_REQ);
            if (!found && en && req[cand]) begin
                grant[cand] = 1'b1;
                idx         = cand;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/shifter_arbiter.sv
// -----------------------------------------------------------------------------
// shifter_arbiter
// Shares one Barrel_Shifter between NUM_REQ requesters with round-robin
// arbitration. The winner's operands are captured, shifted in the following
// cycle, and the registered result is returned tagged with the requester ID.
// Optional feature macro: SHIFT_ARB_LOCK_EN (adds REQ_LOCK and grant locking
// for up to LOCK_MAX consecutive grants to one requester).
// Ports:
//   CLK, RST_N          clock, asynchronous active-low reset
//   REQ_VALID/REQ_READY per-requester valid / one-hot accept
//   REQ_DIR             per-requester direction (0 left, 1 right)
//   REQ_AMT             5 bits per requester, slice i = [5i+4:5i]
//   REQ_DATA            32 bits per requester, slice i = [32i+31:32i]
//   REQ_LOCK            per-requester lock request (SHIFT_ARB_LOCK_EN only)
//   RSP_VALID/RSP_READY response handshake
//   RSP_ID, RSP_DATA    owner index and shifted result
// -----------------------------------------------------------------------------
module shifter_arbiter
    import shifter_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned ID_W     = $clog2(NUM_REQ),
    parameter int unsigned LOCK_MAX = 4
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic [NUM_REQ-1:0]        REQ_VALID,
    output logic [NUM_REQ-1:0]        REQ_READY,
    input  logic [NUM_REQ-1:0]        REQ_DIR,
    input  logic [AMT_W*NUM_REQ-1:0]  REQ_AMT,
    input  logic [DATA_W*NUM_REQ-1:0] REQ_DATA,
`ifdef SHIFT_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]        REQ_LOCK,
`endif
    output logic                      RSP_VALID,
    input  logic                      RSP_READY,
    output logic [ID_W-1:0]           RSP_ID,
    output logic [DATA_W-1:0]         RSP_DATA
);

    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("shifter_arbiter: NUM_REQ must be in 2..8");
    end
    if (LOCK_MAX < 1) begin : g_bad_lock_max
        $error("shifter_arbiter: LOCK_MAX must be at least 1");
    end

    localparam logic [ID_W-1:0] LAST_RST = ID_W'(NUM_REQ - 1);

    arb_state_e        state_q, state_d;
    logic [ID_W-1:0]   last_q, last_d;
    logic              dir_q, dir_d;
    logic [AMT_W-1:0]  amt_q, amt_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic [ID_W-1:0]   rsp_id_q, rsp_id_d;

    logic               accept_en;
    logic               accept;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    win_idx;
    logic [ID_W-1:0]    arb_last;
    logic [DATA_W-1:0]  shift_out;

    assign accept_en = (state_q == IDLE) || ((state_q == RESP) && RSP_READY);
    assign accept    = |grant;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_arbiter (
        .req   (REQ_VALID),
        .last  (arb_last),
        .en    (accept_en),
        .grant (grant),
        .idx   (win_idx)
    );

    Barrel_Shifter u_barrel_shifter (
        .D_IN  (data_q),
        .AMT   (amt_q),
        .DIR   (dir_q),
        .D_OUT (shift_out)
    );

`ifdef SHIFT_ARB_LOCK_EN
    localparam int unsigned     CNT_W   = $clog2(LOCK_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(LOCK_MAX - 1);

    logic             lock_q, lock_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_base;
    logic             lock_hit;

    // A lock is only honoured while the holder keeps VALID high. Feeding the
    // arbiter last_q-1 makes its search begin at last_q, so the locked
    // requester wins without a separate priority path.
    always_comb begin
        lock_hit = lock_q && REQ_VALID[last_q];
        arb_last = last_q;
        if (lock_hit) begin
            arb_last = (last_q == '0) ? LAST_RST : last_q - ID_W'(1);
        end
        cnt_base = lock_hit ? cnt_q : '0;
        lock_d   = lock_hit;
        cnt_d    = cnt_base;
        if (accept) begin
            if (REQ_LOCK[win_idx] && (cnt_base < CNT_LIM)) begin
                lock_d = 1'b1;
                cnt_d  = cnt_base + CNT_W'(1);
            end else begin
                lock_d = 1'b0;
                cnt_d  = '0;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            lock_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            lock_q <= lock_d;
            cnt_q  <= cnt_d;
        end
    end
`else
    assign arb_last = last_q;
`endif

    // last_q doubles as the captured requester ID: both update only on accept
    // and always to the winner.
    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        dir_d      = dir_q;
        amt_d      = amt_q;
        data_d     = data_q;
        rsp_data_d = rsp_data_q;
        rsp_id_d   = rsp_id_q;

        case (state_q)
            IDLE: begin
                if (accept) state_d = BUSY;
            end
            BUSY: begin
                state_d    = RESP;
                rsp_data_d = shift_out;
                rsp_id_d   = last_q;
            end
            RESP: begin
                if (RSP_READY) state_d = accept ? BUSY : IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            last_d = win_idx;
            dir_d  = REQ_DIR[win_idx];
            amt_d  = REQ_AMT[win_idx*AMT_W +: AMT_W];
            data_d = REQ_DATA[win_idx*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= IDLE;
            last_q     <= LAST_RST;
            dir_q      <= DIR_LEFT;
            amt_q      <= '0;
            data_q     <= '0;
            rsp_data_q <= '0;
            rsp_id_q   <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            dir_q      <= dir_d;
            amt_q      <= amt_d;
            data_q     <= data_d;
            rsp_data_q <= rsp_data_d;
            rsp_id_q   <= rsp_id_d;
        end
    end

    assign REQ_READY = grant;
    assign RSP_VALID = (state_q == RESP);
    assign RSP_ID    = rsp_id_q;
    assign RSP_DATA  = rsp_data_q;

endmodule

// File: tb/tb_shifter_arbiter.sv
// -----------------------------------------------------------------------------
// tb_shifter_arbiter
// Directed and randomized checks of shifter_arbiter (NUM_REQ=4) against a
// transaction-level reference model: round-robin winner search, shift by
// plain << / >>, and a one-deep in-flight slot feeding a one-deep response.
// -----------------------------------------------------------------------------
module tb_shifter_arbiter;

    localparam int N = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  req_valid = '0;
    logic [N-1:0]  req_ready;
    logic [N-1:0]  req_dir = '0;
    logic [5*N-1:0]  req_amt = '0;
    logic [32*N-1:0] req_data = '0;
`ifdef SHIFT_ARB_LOCK_EN
    logic [N-1:0]  req_lock = '0;
`endif
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [1:0]    rsp_id;
    logic [31:0]   rsp_data;

    always #5 clk = ~clk;

    shifter_arbiter #(
        .NUM_REQ  (N),
        .LOCK_MAX (4)
    ) dut (
        .CLK       (clk),
        .RST_N     (rst_n),
        .REQ_VALID (req_valid),
        .REQ_READY (req_ready),
        .REQ_DIR   (req_dir),
        .REQ_AMT   (req_amt),
        .REQ_DATA  (req_data),
`ifdef SHIFT_ARB_LOCK_EN
        .REQ_LOCK  (req_lock),
`endif
        .RSP_VALID (rsp_valid),
        .RSP_READY (rsp_ready),
        .RSP_ID    (rsp_id),
        .RSP_DATA  (rsp_data)
    );

    int unsigned total = 0;
    int unsigned passed = 0;
    int unsigned failed = 0;

    // Reference model: one operation in flight, one result on offer.
    bit          m_busy;
    bit          m_rv;
    int          m_last;
    int          m_bid;
    logic [31:0] m_bres;
    int          m_rid;
    logic [31:0] m_rdata;
    int          grant_log[$];

    function automatic logic [31:0] shift_ref(input logic d, input int amt, input logic [31:0] x);
        return d ? (x >> amt) : (x << amt);
    endfunction

    function automatic int rr_pick(input int last, input logic [N-1:0] v);
        int i;
        for (int k = 1; k <= N; k++) begin
            i = (last + k) % N;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    function automatic int onehot_idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 1'b0;
        m_rv   = 1'b0;
        m_last = N - 1;
    endtask

    task automatic set_req(input int i, input logic d, input logic [4:0] a, input logic [31:0] x);
        req_dir[i]         = d;
        req_amt[5*i +: 5]  = a;
        req_data[32*i +: 32] = x;
    endtask

    // Called at posedge+1 with inputs already applied; checks mid-cycle, then
    // advances the model across the next rising edge.
    task automatic step();
        bit           can;
        int           w;
        logic [N-1:0] exp_ready;
        can = (!m_busy && !m_rv) || (m_rv && rsp_ready);
        w   = can ? rr_pick(m_last, req_valid) : -1;
        exp_ready = (w >= 0) ? (N'(1) << w) : '0;
        #4;
        check("req_ready", 32'(req_ready), 32'(exp_ready));
        check("rsp_valid", 32'(rsp_valid), 32'(m_rv));
        if (m_rv) begin
            check("rsp_id", 32'(rsp_id), 32'(m_rid));
            check("rsp_data", rsp_data, m_rdata);
        end
        if (w >= 0) grant_log.push_back(w);
        @(posedge clk);
        if (m_busy) begin
            m_rv    = 1'b1;
            m_rid   = m_bid;
            m_rdata = m_bres;
        end else if (m_rv && rsp_ready) begin
            m_rv = 1'b0;
        end
        m_busy = (w >= 0);
        if (w >= 0) begin
            m_last = w;
            m_bid  = w;
            m_bres = shift_ref(req_dir[w], int'(req_amt[5*w +: 5]), req_data[32*w +: 32]);
        end
        #1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
    endtask

    int exp_rr[5]   = '{0, 1, 2, 3, 0};
    int exp_lock[6] = '{0, 1, 1, 1, 1, 2};

    initial begin
        model_reset();
        // Reset values
        #12;
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_id", 32'(rsp_id), 32'd0);
        check("reset_rsp_data", rsp_data, 32'd0);
        check("reset_req_ready", 32'(req_ready), 32'd0);
        release_reset();

        // Single left shift from requester 2
        rsp_ready = 1'b1;
        set_req(2, 1'b0, 5'd4, 32'h0000_00F1);
        req_valid = 4'b0100;
        step();
        req_valid = '0;
        step();
        check("t1_rsp_valid", 32'(rsp_valid), 32'd1);
        check("t1_rsp_id", 32'(rsp_id), 32'd2);
        check("t1_rsp_data", rsp_data, 32'h0000_0F10);
        step();

        // Full-width right shift
        set_req(0, 1'b1, 5'd31, 32'h8000_0000);
        req_valid = 4'b0001;
        step();
        req_valid = '0;
        step();
        check("t2_rsp_data", rsp_data, 32'h0000_0001);
        check("t2_rsp_id", 32'(rsp_id), 32'd0);
        step();

        // Zero amount passes data through
        set_req(1, 1'b0, 5'd0, 32'hDEAD_BEEF);
        req_valid = 4'b0010;
        step();
        req_valid = '0;
        step();
        check("t3_rsp_data", rsp_data, 32'hDEAD_BEEF);
        check("t3_rsp_id", 32'(rsp_id), 32'd1);
        step();

        // Reset while BUSY drops everything
        for (int i = 0; i < N; i++) set_req(i, 1'($urandom), 5'($urandom), $urandom);
        req_valid = 4'b1111;
        step();
        rst_n = 1'b0;
        req_valid = '0;
        #1;
        check("rst_busy_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_busy_rsp_data", rsp_data, 32'd0);
        check("rst_busy_rsp_id", 32'(rsp_id), 32'd0);
        release_reset();
        repeat (3) step();

        // All requesters valid: fair rotation starting at 0
        grant_log.delete();
        for (int i = 0; i < N; i++) set_req(i, 1'($urandom), 5'($urandom), $urandom);
        req_valid = 4'b1111;
        repeat (10) step();
        for (int i = 0; i < 5; i++)
            check($sformatf("rr_grant%0d", i),
                  (i < grant_log.size()) ? grant_log[i] : -1, exp_rr[i]);

        // Back-pressure: response held, nothing accepted
        rsp_ready = 1'b0;
        repeat (5) step();
        rsp_ready = 1'b1;
        step();
        req_valid = '0;
        repeat (4) step();

        // Randomized traffic
        repeat (400) begin
            req_valid = N'($urandom);
            for (int i = 0; i < N; i++) set_req(i, 1'($urandom), 5'($urandom), $urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            step();
        end

`ifdef SHIFT_ARB_LOCK_EN
        // Requester 1 locks for LOCK_MAX consecutive grants
        rst_n = 1'b0;
        req_valid = '0;
        #2;
        release_reset();
        grant_log.delete();
        rsp_ready = 1'b1;
        req_lock  = 4'b0010;
        req_valid = 4'b1111;
        repeat (12) begin
            #4;
            if (req_ready != '0) grant_log.push_back(onehot_idx(req_ready));
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < 6; i++)
            check($sformatf("lock_grant%0d", i),
                  (i < grant_log.size()) ? grant_log[i] : -1, exp_lock[i]);
        req_lock  = '0;
        req_valid = '0;
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
